// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_ADDR_W = 16;
    localparam int DMEM_DEPTH  = 256;

    // Responder state: clearing the array after reset, or servicing traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Which requester owns the single array port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_CPU   = 2'd1,
        SEL_HOST  = 2'd2,
        SEL_CLEAR = 2'd3
    } sel_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with registered read data.
module dmem_array #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [0:DATA_W-1] wdata,
    output logic [0:DATA_W-1] rdata
);

    logic [0:DATA_W-1] mem [DEPTH];
    logic [0:DATA_W-1] rdata_q;

    // One access per cycle: write commits, or read lands in rdata_q.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata_q <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: CPU memory-stage port with priority over a host
// port, one-cycle registered load latency, and an array clear after reset.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int DATA_W = DMEM_DATA_W,
    parameter  int ADDR_W = DMEM_ADDR_W,
    parameter  int DEPTH  = DMEM_DEPTH,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memEn,
    input  logic              cpu_memwrEn,
    input  logic [0:ADDR_W-1] cpu_addr,
    input  logic [0:DATA_W-1] cpu_wdata,
    output logic [0:DATA_W-1] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [0:ADDR_W-1] host_addr,
    input  logic [0:DATA_W-1] host_wdata,
    output logic              host_gnt,
    output logic [0:DATA_W-1] host_rdata,
    output logic              host_rvalid,
    output logic              init_done,
    output logic              drop_err
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;
    logic              init_done_q, init_done_d;
    logic              drop_err_q, drop_err_d;
    logic              rd_valid_q, rd_valid_d;
    logic              resp_host_q, resp_host_d;
    logic [0:DATA_W-1] cpu_hold_q, cpu_hold_d;
    logic [0:DATA_W-1] host_hold_q, host_hold_d;

    sel_e              sel;
    logic [IDX_W-1:0]  cpu_idx, host_idx;
    logic              arr_en, arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [0:DATA_W-1] arr_wdata, arr_rdata;

    // Upper address bits are ignored, so addresses alias modulo DEPTH.
    assign cpu_idx  = cpu_addr[ADDR_W-IDX_W:ADDR_W-1];
    assign host_idx = host_addr[ADDR_W-IDX_W:ADDR_W-1];

    logic unused_addr_hi;
    assign unused_addr_hi = ^{cpu_addr[0:ADDR_W-IDX_W-1], host_addr[0:ADDR_W-IDX_W-1]};

    assign host_gnt = init_done_q & host_req & ~cpu_memEn;

    // Port ownership: clear sweep, then CPU, then granted host.
    always_comb begin
        sel = SEL_NONE;
        if (state_q == CLEAR) begin
            sel = SEL_CLEAR;
        end else if (cpu_memEn) begin
            sel = SEL_CPU;
        end else if (host_gnt) begin
            sel = SEL_HOST;
        end
    end

    // Array port mux driven by the current owner.
    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_idx   = '0;
        arr_wdata = '0;
        unique case (sel)
            SEL_CLEAR: begin
                arr_en  = 1'b1;
                arr_we  = 1'b1;
                arr_idx = clear_ptr_q;
            end
            SEL_CPU: begin
                arr_en    = 1'b1;
                arr_we    = cpu_memwrEn;
                arr_idx   = cpu_idx;
                arr_wdata = cpu_wdata;
            end
            SEL_HOST: begin
                arr_en    = 1'b1;
                arr_we    = host_wr;
                arr_idx   = host_idx;
                arr_wdata = host_wdata;
            end
            default: ;
        endcase
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Response routing: array read data is live only in the response cycle,
    // so each port keeps a holding copy for the cycles in between.
    assign cpu_rvalid  = rd_valid_q & ~resp_host_q;
    assign host_rvalid = rd_valid_q & resp_host_q;
    assign cpu_rdata   = cpu_rvalid  ? arr_rdata : cpu_hold_q;
    assign host_rdata  = host_rvalid ? arr_rdata : host_hold_q;

    // Next-state logic for the clear FSM and response tracking.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        init_done_d = init_done_q;
        if (state_q == CLEAR) begin
            clear_ptr_d = clear_ptr_q + 1'b1;
            if (clear_ptr_q == IDX_W'(DEPTH - 1)) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end
        drop_err_d  = (state_q == CLEAR) & (cpu_memEn | host_req);
        rd_valid_d  = ((sel == SEL_CPU)  & ~cpu_memwrEn) |
                      ((sel == SEL_HOST) & ~host_wr);
        resp_host_d = (sel == SEL_HOST);
        cpu_hold_d  = cpu_rdata;
        host_hold_d = host_rdata;
    end

    // State and output registers; reset restarts the clear sweep and
    // discards any read response in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            init_done_q <= 1'b0;
            drop_err_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            resp_host_q <= 1'b0;
            cpu_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            init_done_q <= init_done_d;
            drop_err_q  <= drop_err_d;
            rd_valid_q  <= rd_valid_d;
            resp_host_q <= resp_host_d;
            cpu_hold_q  <= cpu_hold_d;
            host_hold_q <= host_hold_d;
        end
    end

    assign init_done = init_done_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memEn, cpu_memwrEn;
    logic [0:15] cpu_addr;
    logic [0:63] cpu_wdata, cpu_rdata;
    logic        cpu_rvalid;
    logic        host_req, host_wr;
    logic [0:15] host_addr;
    logic [0:63] host_wdata, host_rdata;
    logic        host_gnt, host_rvalid, init_done, drop_err;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] D_A   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D_AL  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] D_H   = 64'h5555_0000_1234_FFFF;
    localparam logic [63:0] D_DRP = 64'hFFFF_FFFF_FFFF_FFFF;

    dmem_responder #(
        .DATA_W (64),
        .ADDR_W (16),
        .DEPTH  (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_memEn   (cpu_memEn),
        .cpu_memwrEn (cpu_memwrEn),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .host_req    (host_req),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .init_done   (init_done),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_memEn   = 1'b0;
        cpu_memwrEn = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        host_req    = 1'b0;
        host_wr     = 1'b0;
        host_addr   = '0;
        host_wdata  = '0;
    endtask

    task automatic cpu_op(input logic wr, input logic [15:0] a, input logic [63:0] d);
        cpu_memEn   = 1'b1;
        cpu_memwrEn = wr;
        cpu_addr    = a;
        cpu_wdata   = d;
    endtask

    task automatic host_op(input logic wr, input logic [15:0] a, input logic [63:0] d);
        host_req   = 1'b1;
        host_wr    = wr;
        host_addr  = a;
        host_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_host_rvalid", 64'(host_rvalid), 64'd0);
        chk("rst_host_rdata", host_rdata, 64'd0);
        chk("rst_drop_err", 64'(drop_err), 64'd0);
        reset = 1'b0;

        // Edge k is the k-th edge with reset low; store attempt before edge 3.
        for (int k = 1; k <= 256; k++) begin
            idle();
            if (k == 3) begin
                cpu_op(1'b1, 16'h0007, D_DRP);
                host_op(1'b0, 16'h0007, 64'd0);
                #1;
                chk("clear_host_gnt", 64'(host_gnt), 64'd0);
            end
            tick();
            if (k == 3) chk("drop_pulse", 64'(drop_err), 64'd1);
            if (k == 4) chk("drop_single", 64'(drop_err), 64'd0);
            if (k == 255) chk("init_not_yet", 64'(init_done), 64'd0);
            if (k == 256) chk("init_rise", 64'(init_done), 64'd1);
        end
        idle();

        // Host readback of a cleared location.
        host_op(1'b0, 16'h00FF, 64'd0);
        #1;
        chk("host_gnt_free", 64'(host_gnt), 64'd1);
        tick();
        idle();
        chk("host_rvalid_ff", 64'(host_rvalid), 64'd1);
        chk("host_rdata_ff", host_rdata, 64'd0);
        tick();
        chk("host_rvalid_pulse", 64'(host_rvalid), 64'd0);

        // Store then immediately load the same index, held two cycles.
        cpu_op(1'b1, 16'h0005, D_A);
        tick();
        chk("store_no_rvalid", 64'(cpu_rvalid), 64'd0);
        cpu_op(1'b0, 16'h0005, 64'd0);
        tick();
        chk("load1_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("load1_data", cpu_rdata, D_A);
        tick();
        idle();
        chk("load2_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("load2_data", cpu_rdata, D_A);
        tick();
        chk("load_rvalid_off", 64'(cpu_rvalid), 64'd0);
        chk("load_data_hold", cpu_rdata, D_A);

        // Dropped store must not have landed.
        cpu_op(1'b0, 16'h0007, 64'd0);
        tick();
        idle();
        chk("drop_loc_zero", cpu_rdata, 64'd0);

        // Host write, then contended host read against a two-cycle CPU load.
        host_op(1'b1, 16'h0010, D_H);
        tick();
        chk("host_wr_no_rvalid", 64'(host_rvalid), 64'd0);
        host_op(1'b0, 16'h0010, 64'd0);
        cpu_op(1'b0, 16'h0005, 64'd0);
        #1;
        chk("arb_gnt_c1", 64'(host_gnt), 64'd0);
        tick();
        chk("arb_gnt_c2", 64'(host_gnt), 64'd0);
        chk("arb_cpu_rv_c2", 64'(cpu_rvalid), 64'd1);
        tick();
        cpu_memEn = 1'b0;
        #1;
        chk("arb_gnt_c3", 64'(host_gnt), 64'd1);
        chk("arb_host_rv_c3", 64'(host_rvalid), 64'd0);
        tick();
        idle();
        chk("arb_host_rv", 64'(host_rvalid), 64'd1);
        chk("arb_host_data", host_rdata, D_H);
        chk("arb_cpu_rv_off", 64'(cpu_rvalid), 64'd0);
        chk("arb_cpu_hold", cpu_rdata, D_A);

        // Aliasing: 0x0105 maps onto index 0x05.
        cpu_op(1'b1, 16'h0105, D_AL);
        tick();
        cpu_op(1'b0, 16'h0005, 64'd0);
        tick();
        chk("alias_data", cpu_rdata, D_AL);
        chk("host_hold", host_rdata, D_H);

        // Reset in the same cycle as a load.
        reset = 1'b1;
        tick();
        idle();
        reset = 1'b0;
        chk("rst_mid_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("rst_mid_init", 64'(init_done), 64'd0);
        chk("rst_mid_rdata", cpu_rdata, 64'd0);
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 255) chk("reclear_not_yet", 64'(init_done), 64'd0);
            if (k == 256) chk("reclear_done", 64'(init_done), 64'd1);
        end
        cpu_op(1'b0, 16'h0005, 64'd0);
        tick();
        idle();
        chk("reclear_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("reclear_data", cpu_rdata, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the CPU memory-stage request interface.
- Accepts load/store requests (memEn, memwrEn, word address, 64-bit store data) and returns registered load data one cycle later. This matches the CPU's fixed one-cycle load stall.
- Also serves a lower-priority host port, used for testbench/NoC preload and readback.
- After reset it clears its array before accepting traffic.

Parameters:
DATA_W, 64, data word width; bit 0 is the MSB ([0:DATA_W-1] ordering)
ADDR_W, 16, request address width (word address)
DEPTH, 256, number of words; must be a power of two
IDX_W, log2(DEPTH), array index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_memEn  in  1  CPU memory request this cycle
cpu_memwrEn  in  1  1 = store, 0 = load (valid only when cpu_memEn=1)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  load data, registered
cpu_rvalid  out  1  cpu_rdata updated this cycle
host_req  in  1  host request
host_wr  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host word address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host request accepted this cycle (combinational)
host_rdata  out  DATA_W  host read data, registered
host_rvalid  out  1  host_rdata updated this cycle
init_done  out  1  array clear finished; ports live
drop_err  out  1  pulse: a request arrived during CLEAR and was discarded

Behaviour:
- Reset values: cpu_rdata=0, cpu_rvalid=0, host_rdata=0, host_rvalid=0, init_done=0, drop_err=0, state=CLEAR, clear_ptr=0.
- FSM states:
  - CLEAR: write 0 to array[clear_ptr] each cycle and increment clear_ptr. When clear_ptr==DEPTH-1 has been written, go to RUN and set init_done=1 on the following cycle. CLEAR lasts exactly DEPTH cycles after reset deasserts.
  - RUN: service requests. Stay in RUN until reset.
- Reset mid-operation: return to CLEAR and restart clear_ptr at 0. Any in-flight read response is discarded (rvalid=0).
- CLEAR-phase requests: any cpu_memEn or host_req during CLEAR is ignored. drop_err=1 the next cycle, a single-cycle pulse per offending cycle. host_gnt=0 throughout CLEAR.
- Index: idx = addr[ADDR_W-IDX_W : ADDR_W-1] (low-order bits). Upper address bits are ignored, so addresses alias modulo DEPTH.
- CPU load (memEn=1, memwrEn=0) in cycle N: array read at the end of N; cpu_rdata valid with cpu_rvalid=1 in N+1.
  - The CPU holds a load for two cycles, so a second identical read occurs. Reads are side-effect free.
  - cpu_rdata holds its value until the next CPU load completes.
- CPU store (memEn=1, memwrEn=1) in cycle N: array[idx] <= cpu_wdata at the end of N. No response; cpu_rvalid=0.
- Arbitration: the CPU has absolute priority. host_gnt = init_done & host_req & ~cpu_memEn. A host request that is not granted must be held by the host until it is granted.
- Host read granted in N: host_rdata and host_rvalid=1 in N+1. Host write granted in N: commits at the end of N.
- Read-after-write: a store in N followed by a load of the same index in N+1 returns the new data in N+2. Only one array access occurs per cycle, so there are no same-cycle read/write collisions.
- rvalid outputs are single-cycle pulses per accepted read; they are 0 in all other cycles.
- Storage is word-granular only; no partial-write masks.

Decomposition:
- Package dmem_pkg holds:
  - DATA_W and ADDR_W defaults
  - state encoding (CLEAR=1'b0, RUN=1'b1)
  - port-select constants (SEL_NONE, SEL_CPU, SEL_HOST, SEL_CLEAR)
- Sub-module dmem_array: single-port synchronous RAM (DEPTH x DATA_W) with en, we, idx, wdata, and a registered rdata.
- The top level contains the clear FSM, the arbitration mux, and response routing (which port's rvalid fires, tracked by a 1-bit registered select).

Test Plan:
- Reset clear: deassert reset, count cycles → init_done rises at cycle DEPTH+1 (257). A host read of addr 0x00FF afterwards returns 0.
- CPU store/load: store 0x0123456789ABCDEF to addr 0x0005. Then hold a load of 0x0005 for 2 cycles → cpu_rvalid=1 in both following cycles with that data.
- Aliasing: store 0xAAAA... to addr 0x0105 → a load of 0x0005 returns 0xAAAA... (DEPTH=256).
- Arbitration: host_req read of 0x0010 concurrent with a 2-cycle CPU load → host_gnt=0 for 2 cycles, granted in the 3rd. host_rvalid follows one cycle later with the stored value.
- Drop during clear: assert cpu_memEn=1 store at cycle 3 after reset → drop_err pulses at cycle 4. After init_done, the location reads 0.
- Reset mid-read: load issued in N with reset asserted in N → cpu_rvalid=0 in N+1, init_done=0, and CLEAR restarts.
